div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring divider (one quotient bit per cycle).
//
// Optional feature: define DIV_SIGNED_EN to enable signed division (DIV).
// Without it every request is treated as unsigned (DIVU), signed_div_i is
// ignored and no negation logic is built.
//
// Ports
//   clk          : clock, rising-edge active
//   resetn       : synchronous active-low reset
//   start_i      : division request, held high until the result is consumed
//   annul_i      : abort the division in progress
//   signed_div_i : 1 = signed, 0 = unsigned (only honoured with DIV_SIGNED_EN)
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   result_o     : {remainder, quotient}, zero whenever ready_o is low
//   ready_o      : result_o is valid
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   divisor_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quot_q;

  logic                accept;
  logic                last_step;
  logic [DATA_W-1:0]   dividend_in;
  logic [DATA_W-1:0]   divisor_in;
  logic [DATA_W:0]     rem_sh;
  logic                step_ge;
  logic [DATA_W-1:0]   step_rem;
  logic [DATA_W-1:0]   step_quot;
  logic [DATA_W-1:0]   fin_rem;
  logic [DATA_W-1:0]   fin_quot;

  assign accept    = start_i && !annul_i;
  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

`ifdef DIV_SIGNED_EN
  logic neg_a, neg_b;
  logic neg_quot_q, neg_rem_q;

  assign neg_a       = signed_div_i && opdata1_i[DATA_W-1];
  assign neg_b       = signed_div_i && opdata2_i[DATA_W-1];
  // Iterate on magnitudes; signs are restored on the final step.
  assign dividend_in = neg_a ? -opdata1_i : opdata1_i;
  assign divisor_in  = neg_b ? -opdata2_i : opdata2_i;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign dividend_in       = opdata1_i;
  assign divisor_in        = opdata2_i;
`endif

  // One restoring step: the shifted partial remainder needs DATA_W+1 bits,
  // but after a successful subtraction it is below the divisor again, so the
  // low DATA_W bits of the difference are exact.
  always_comb begin
    rem_sh    = {rem_q, quot_q[DATA_W-1]};
    step_ge   = (rem_sh >= {1'b0, divisor_q});
    step_rem  = step_ge ? (rem_sh[DATA_W-1:0] - divisor_q) : rem_sh[DATA_W-1:0];
    step_quot = {quot_q[DATA_W-2:0], step_ge};
`ifdef DIV_SIGNED_EN
    fin_rem   = (last_step && neg_rem_q)  ? -step_rem  : step_rem;
    fin_quot  = (last_step && neg_quot_q) ? -step_quot : step_quot;
`else
    fin_rem   = step_rem;
    fin_quot  = step_quot;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    result_o = '0;
    case (state_q)
      FREE: begin
        if (accept) begin
          state_d = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        state_d = END;
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
        end else if (last_step) begin
          state_d = END;
        end
      end
      END: begin
        ready_o  = 1'b1;
        result_o = {rem_q, quot_q};
        if (!start_i) begin
          state_d = FREE;
        end
      end
      default: begin
        state_d = FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        FREE: begin
          if (accept) begin
            quot_q     <= dividend_in;
            rem_q      <= '0;
            divisor_q  <= divisor_in;
            cnt_q      <= '0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
`endif
          end
        end
        BYZERO: begin
          quot_q <= '0;
          rem_q  <= '0;
        end
        ON: begin
          if (!annul_i) begin
            rem_q  <= fin_rem;
            quot_q <= fin_quot;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
